// File: rtl/motor_config_bank.sv
`timescale 1ns/1ps
// motor_config_bank: Avalon-MM register bank holding per-motor control configuration
// and status. Motors with unsent configuration changes are marked dirty and their
// configuration snapshots are offered round-robin over a valid/ready handshake.
// Optional build macro CONFIG_WRITE_LOCK_EN adds a global write-lock register at 0x30.
module motor_config_bank #(
    parameter int NUM_MOTORS        = 8,
    parameter int ID_BASE           = 128,
    parameter int DEFAULT_PWM_LIMIT = 500,
    parameter int DEFAULT_INT_LIMIT = 100,
    parameter int DEFAULT_MODE      = 3,
    parameter int DEFAULT_UPDATE_HZ = 100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           address,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic                  read,
    output logic [31:0]           readdata,
    output logic                  waitrequest,
    input  logic                  status_valid,
    input  logic [7:0]            status_motor,
    input  logic [84:0]           status_data,
    output logic                  cfg_valid,
    input  logic                  cfg_ready,
    output logic [7:0]            cfg_motor,
    output logic [159:0]          cfg_data,
    output logic [31:0]           update_frequency_hz,
    output logic [NUM_MOTORS-1:0] dirty
);
    localparam int IDX_W  = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
    localparam int DPAD_W = (NUM_MOTORS > 32) ? NUM_MOTORS : 32;

    localparam logic [7:0] REG_ID       = 8'h00;
    localparam logic [7:0] REG_KP       = 8'h01;
    localparam logic [7:0] REG_KI       = 8'h02;
    localparam logic [7:0] REG_KD       = 8'h03;
    localparam logic [7:0] REG_ENC0     = 8'h04;
    localparam logic [7:0] REG_ENC1     = 8'h05;
    localparam logic [7:0] REG_PWM      = 8'h08;
    localparam logic [7:0] REG_INT      = 8'h09;
    localparam logic [7:0] REG_DEADBAND = 8'h0A;
    localparam logic [7:0] REG_MODE     = 8'h0B;
    localparam logic [7:0] REG_SETPOINT = 8'h0C;
    localparam logic [7:0] REG_FREQ     = 8'h11;
    localparam logic [7:0] REG_COLOUR   = 8'h12;
    localparam logic [7:0] REG_DUTY     = 8'h17;
    localparam logic [7:0] REG_CURRENT  = 8'h19;
    localparam logic [7:0] REG_DIRTY    = 8'h20;
`ifdef CONFIG_WRITE_LOCK_EN
    localparam logic [7:0] REG_LOCK     = 8'h30;
`endif

    typedef enum logic {S_IDLE, S_OFFER} state_t;

    // Per-motor configuration
    logic [7:0]  id_r        [NUM_MOTORS];
    logic [15:0] kp_r        [NUM_MOTORS];
    logic [15:0] ki_r        [NUM_MOTORS];
    logic [15:0] kd_r        [NUM_MOTORS];
    logic [23:0] setpoint_r  [NUM_MOTORS];
    logic [23:0] pwm_limit_r [NUM_MOTORS];
    logic [23:0] int_limit_r [NUM_MOTORS];
    logic [23:0] deadband_r  [NUM_MOTORS];
    logic [7:0]  mode_r      [NUM_MOTORS];
    logic [23:0] colour_r    [NUM_MOTORS];

    // Per-motor status pushed by the comms engine
    logic [23:0]        enc0_r    [NUM_MOTORS];
    logic [23:0]        enc1_r    [NUM_MOTORS];
    logic [23:0]        duty_r    [NUM_MOTORS];
    logic signed [12:0] current_r [NUM_MOTORS];

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic               rd_done;

    logic [7:0]         reg_sel;
    logic [IDX_W-1:0]   m_idx;
    logic               motor_ok;
    logic               is_cfg_reg;
    logic               wr_blocked;
    logic               cfg_wr;
    logic               colour_wr;
    logic               freq_wr;
    logic [IDX_W-1:0]   s_idx;
    logic               status_ok;
    logic [31:0]        rd_value;
    logic [DPAD_W-1:0]  dirty_pad;

    int                 pick_sum;
    logic [IDX_W-1:0]   pick_cand;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [159:0]       snap;
    logic [IDX_W-1:0]   next_ptr;
    logic [NUM_MOTORS-1:0] dirty_set;
    logic [NUM_MOTORS-1:0] dirty_clr;

`ifdef CONFIG_WRITE_LOCK_EN
    logic               lock_r;
    logic [15:0]        lock_cnt;
    logic               lock_hit;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    assign reg_sel   = address[15:8];
    assign m_idx     = address[IDX_W-1:0];
    assign motor_ok  = (int'(address[7:0]) < NUM_MOTORS);
    assign s_idx     = status_motor[IDX_W-1:0];
    assign status_ok = (int'(status_motor) < NUM_MOTORS);
    assign dirty_pad = DPAD_W'(dirty);

    assign is_cfg_reg = (reg_sel == REG_ID)  || (reg_sel == REG_KP) || (reg_sel == REG_KI) ||
                        (reg_sel == REG_KD)  || (reg_sel == REG_PWM) || (reg_sel == REG_INT) ||
                        (reg_sel == REG_DEADBAND) || (reg_sel == REG_MODE) ||
                        (reg_sel == REG_SETPOINT);

`ifdef CONFIG_WRITE_LOCK_EN
    assign wr_blocked = lock_r;
    assign lock_hit   = write && lock_r &&
                        ((motor_ok && (is_cfg_reg || (reg_sel == REG_COLOUR))) || (reg_sel == REG_FREQ));
`else
    assign wr_blocked = 1'b0;
`endif

    assign cfg_wr    = write && motor_ok && is_cfg_reg && !wr_blocked;
    assign colour_wr = write && motor_ok && (reg_sel == REG_COLOUR) && !wr_blocked;
    assign freq_wr   = write && (reg_sel == REG_FREQ) && !wr_blocked;

    // Read-only waitrequest for the first cycle of every read; writes never stall.
    assign waitrequest = read && !rd_done;

    // Read mux: per-motor fields need a valid motor index, global fields ignore it.
    always_comb begin
        rd_value = 32'hDEADBEEF;
        if (motor_ok) begin
            case (reg_sel)
                REG_ID:       rd_value = {24'd0, id_r[m_idx]};
                REG_KP:       rd_value = {16'd0, kp_r[m_idx]};
                REG_KI:       rd_value = {16'd0, ki_r[m_idx]};
                REG_KD:       rd_value = {16'd0, kd_r[m_idx]};
                REG_ENC0:     rd_value = {8'd0, enc0_r[m_idx]};
                REG_ENC1:     rd_value = {8'd0, enc1_r[m_idx]};
                REG_PWM:      rd_value = {8'd0, pwm_limit_r[m_idx]};
                REG_INT:      rd_value = {8'd0, int_limit_r[m_idx]};
                REG_DEADBAND: rd_value = {8'd0, deadband_r[m_idx]};
                REG_MODE:     rd_value = {24'd0, mode_r[m_idx]};
                REG_SETPOINT: rd_value = {8'd0, setpoint_r[m_idx]};
                REG_COLOUR:   rd_value = {8'd0, colour_r[m_idx]};
                REG_DUTY:     rd_value = {8'd0, duty_r[m_idx]};
                REG_CURRENT:  rd_value = 32'(current_r[m_idx]);
                default:      rd_value = 32'hDEADBEEF;
            endcase
        end
        case (reg_sel)
            REG_FREQ:  rd_value = update_frequency_hz;
            REG_DIRTY: rd_value = dirty_pad[31:0];
`ifdef CONFIG_WRITE_LOCK_EN
            REG_LOCK:  rd_value = {lock_cnt, 15'd0, lock_r};
`endif
            default:   ;
        endcase
    end

    // Register read data on the waitrequest cycle; the read completes on the next.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_done  <= 1'b0;
            readdata <= 32'd0;
        end else begin
            rd_done <= read && !rd_done;
            if (read && !rd_done) readdata <= rd_value;
        end
    end

    // Per-motor configuration and colour registers; accepted writes truncate to field width.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_MOTORS; i++) begin
                id_r[i]        <= 8'(ID_BASE + i);
                kp_r[i]        <= 16'd1;
                ki_r[i]        <= 16'd0;
                kd_r[i]        <= 16'd0;
                setpoint_r[i]  <= 24'd0;
                pwm_limit_r[i] <= 24'(DEFAULT_PWM_LIMIT);
                int_limit_r[i] <= 24'(DEFAULT_INT_LIMIT);
                deadband_r[i]  <= 24'd0;
                mode_r[i]      <= 8'(DEFAULT_MODE);
                colour_r[i]    <= 24'd0;
            end
        end else if (cfg_wr || colour_wr) begin
            case (reg_sel)
                REG_ID:       id_r[m_idx]        <= writedata[7:0];
                REG_KP:       kp_r[m_idx]        <= writedata[15:0];
                REG_KI:       ki_r[m_idx]        <= writedata[15:0];
                REG_KD:       kd_r[m_idx]        <= writedata[15:0];
                REG_PWM:      pwm_limit_r[m_idx] <= writedata[23:0];
                REG_INT:      int_limit_r[m_idx] <= writedata[23:0];
                REG_DEADBAND: deadband_r[m_idx]  <= writedata[23:0];
                REG_MODE:     mode_r[m_idx]      <= writedata[7:0];
                REG_SETPOINT: setpoint_r[m_idx]  <= writedata[23:0];
                REG_COLOUR:   colour_r[m_idx]    <= writedata[23:0];
                default:      ;
            endcase
        end
    end

    // Status pushes land at the edge; out-of-range motor indices are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_MOTORS; i++) begin
                enc0_r[i]    <= 24'd0;
                enc1_r[i]    <= 24'd0;
                duty_r[i]    <= 24'd0;
                current_r[i] <= 13'sd0;
            end
        end else if (status_valid && status_ok) begin
            enc0_r[s_idx]    <= status_data[23:0];
            enc1_r[s_idx]    <= status_data[47:24];
            duty_r[s_idx]    <= status_data[71:48];
            current_r[s_idx] <= signed'(status_data[84:72]);
        end
    end

    // Global update frequency register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) update_frequency_hz <= 32'(DEFAULT_UPDATE_HZ);
        else if (freq_wr) update_frequency_hz <= writedata;
    end

`ifdef CONFIG_WRITE_LOCK_EN
    // Lock register: always writable; rejected writes counted with saturation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_r   <= 1'b0;
            lock_cnt <= 16'd0;
        end else if (write && (reg_sel == REG_LOCK)) begin
            lock_r <= writedata[0];
            if (writedata[1]) lock_cnt <= 16'd0;
        end else if (lock_hit) begin
            lock_cnt <= sat_inc16(lock_cnt);
        end
    end
`endif

    // Round-robin search: first dirty motor at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_sum   = 0;
        pick_cand  = '0;
        for (int k = 0; k < NUM_MOTORS; k++) begin
            pick_sum = int'(rr_ptr) + k;
            if (pick_sum >= NUM_MOTORS) pick_sum = pick_sum - NUM_MOTORS;
            pick_cand = IDX_W'(pick_sum);
            if (!pick_found && dirty[pick_cand]) begin
                pick_found = 1'b1;
                pick_idx   = pick_cand;
            end
        end
    end

    assign snap = {mode_r[pick_idx], deadband_r[pick_idx], int_limit_r[pick_idx],
                   pwm_limit_r[pick_idx], setpoint_r[pick_idx], kd_r[pick_idx],
                   ki_r[pick_idx], kp_r[pick_idx], id_r[pick_idx]};

    assign next_ptr  = (int'(cfg_motor) >= NUM_MOTORS - 1) ? '0 : IDX_W'(int'(cfg_motor) + 1);
    assign dirty_set = cfg_wr ? (NUM_MOTORS'(1) << m_idx) : '0;
    assign dirty_clr = ((state == S_IDLE) && pick_found) ? (NUM_MOTORS'(1) << pick_idx) : '0;

    // Offer scheduler: snapshot in IDLE, hold in OFFER until accepted; a set beats a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cfg_valid <= 1'b0;
            cfg_motor <= 8'd0;
            cfg_data  <= 160'd0;
            rr_ptr    <= '0;
            dirty     <= '1;
        end else begin
            dirty <= (dirty & ~dirty_clr) | dirty_set;
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        cfg_motor <= 8'(pick_idx);
                        cfg_data  <= snap;
                        cfg_valid <= 1'b1;
                        state     <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (cfg_ready) begin
                        cfg_valid <= 1'b0;
                        rr_ptr    <= next_ptr;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
